// File: rtl/clock_mode_if.sv
// Button inputs and registered control outputs between the front panel and the clock datapath.
// The controller takes the slave modport. Button sources and observers take the master modport.
interface clock_mode_if;
  logic       mode;
  logic       set;
  logic       op1;
  logic       op2;
  logic [1:0] mode_sel;
  logic [1:0] field_sel;
  logic       inc;
  logic       dec;
  logic       commit;
  logic       alarm_en;
  logic       sw_run;
  logic       sw_clear;
  logic       blink_on;

  modport master (
    output mode, set, op1, op2,
    input  mode_sel, field_sel, inc, dec, commit, alarm_en, sw_run, sw_clear, blink_on
  );

  modport slave (
    input  mode, set, op1, op2,
    output mode_sel, field_sel, inc, dec, commit, alarm_en, sw_run, sw_clear, blink_on
  );
endinterface

// File: rtl/clock_mode_controller.sv
// Front-panel sequencer: button edges -> mode/field selection, set strobes, stopwatch control, blink, timeout.
// Optional build macro AUTO_REPEAT_EN: a held op button re-issues inc/dec while setting.
module clock_mode_controller #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SET_TIMEOUT  = 10,
  parameter int unsigned BLINK_HALF   = 1,
  parameter int unsigned REPEAT_DELAY = 2,
  parameter int unsigned REPEAT_RATE  = 1
) (
  input logic         clk,
  input logic         reset,
  clock_mode_if.slave bus
);

`ifdef AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW   = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT) : 1;
  localparam int unsigned BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [1:0] MODE_CLOCK = 2'd0;
  localparam logic [1:0] MODE_ALARM = 2'd1;
  localparam logic [1:0] MODE_SW    = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  state_t        state;
  logic [1:0]    mode_sel, field_sel;
  logic          inc, dec, commit, alarm_en, sw_run, sw_clear, blink_on;
  logic [3:0]    btn, btn_q, btn_rise;
  logic [PW-1:0] presc;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [RW-1:0] rcnt;
  logic          rpt_act, rpt_armed;

  logic tick, in_set, any_edge;
  logic act_mode, act_set, act_op1, act_op2;
  logic hold_inc, hold_dec, rpt_hit, rpt_fire, t_expire, b_flip;

  assign btn      = {bus.mode, bus.set, bus.op1, bus.op2};
  assign btn_rise = btn & ~btn_q;
  assign any_edge = |btn_rise;

  // Only the highest-priority edge acts: mode > set > op1 > op2.
  assign act_mode = btn_rise[3];
  assign act_set  = btn_rise[2] & ~btn_rise[3];
  assign act_op1  = btn_rise[1] & ~|btn_rise[3:2];
  assign act_op2  = btn_rise[0] & ~|btn_rise[3:1];

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign in_set   = (state != RUN);
  assign hold_inc = bus.op1 & ~bus.op2;
  assign hold_dec = bus.op2 & ~bus.op1;

  assign rpt_hit  = ((32'(rcnt) + 32'd1) == (rpt_armed ? REPEAT_RATE : REPEAT_DELAY));
  assign rpt_fire = RPT_EN && rpt_act && in_set && (hold_inc || hold_dec) && !any_edge && tick && rpt_hit;
  assign t_expire = in_set && tick && !any_edge && !rpt_fire && ((32'(tcnt) + 32'd1) == SET_TIMEOUT);
  assign b_flip   = tick && ((32'(bcnt) + 32'd1) == BLINK_HALF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      mode_sel  <= MODE_CLOCK;
      field_sel <= FIELD_NONE;
      inc       <= 1'b0;
      dec       <= 1'b0;
      commit    <= 1'b0;
      sw_clear  <= 1'b0;
      alarm_en  <= 1'b0;
      sw_run    <= 1'b0;
      blink_on  <= 1'b1;
      // NOTE: edge history resets to "pressed" so a button held through reset must be released before it counts.
      btn_q     <= '1;
      presc     <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      rpt_act   <= 1'b0;
      rpt_armed <= 1'b0;
    end else begin
      btn_q <= btn;
      presc <= tick ? '0 : presc + PW'(1);
      // NOTE: strobes default low every cycle so each one lasts exactly one clock; later assignments override.
      inc      <= 1'b0;
      dec      <= 1'b0;
      commit   <= 1'b0;
      sw_clear <= 1'b0;

      if (in_set && (act_op1 || act_op2)) begin
        rpt_act   <= 1'b1;
        rpt_armed <= 1'b0;
        rcnt      <= '0;
      end else if (!in_set || !(hold_inc || hold_dec) || any_edge) begin
        rpt_act   <= 1'b0;
        rpt_armed <= 1'b0;
        rcnt      <= '0;
      end else if (rpt_act && tick) begin
        if (rpt_hit) begin
          rpt_armed <= 1'b1;
          rcnt      <= '0;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end

      case (state)
        RUN: begin
          blink_on <= 1'b1;
          tcnt     <= '0;
          bcnt     <= '0;
          if (act_mode) begin
            mode_sel <= (mode_sel == MODE_SW) ? MODE_CLOCK : mode_sel + 2'd1;
          end else if (act_set && mode_sel != MODE_SW) begin
            state     <= SET_H;
            field_sel <= FIELD_HOUR;
          end else if (act_op1) begin
            if (mode_sel == MODE_ALARM) alarm_en <= ~alarm_en;
            else if (mode_sel == MODE_SW) sw_run <= ~sw_run;
          end else if (act_op2 && mode_sel == MODE_SW && !sw_run) begin
            sw_clear <= 1'b1;
          end
        end
        default: begin
          if (act_set || t_expire) begin
            blink_on <= 1'b1;
            tcnt     <= '0;
            bcnt     <= '0;
            if (act_set && state == SET_H) begin
              state     <= SET_M;
              field_sel <= FIELD_MIN;
            end else if (act_set && state == SET_M) begin
              state     <= SET_S;
              field_sel <= FIELD_SEC;
            end else begin
              state     <= RUN;
              field_sel <= FIELD_NONE;
              commit    <= 1'b1;
            end
          end else begin
            inc <= act_op1 | (rpt_fire & hold_inc);
            dec <= act_op2 | (rpt_fire & hold_dec);
            // Any button activity, including a repeat strobe, restarts the inactivity window.
            if (any_edge || rpt_fire) tcnt <= '0;
            else if (tick)            tcnt <= tcnt + TW'(1);
            if (b_flip) begin
              bcnt     <= '0;
              blink_on <= ~blink_on;
            end else if (tick) begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.mode_sel  = mode_sel;
  assign bus.field_sel = field_sel;
  assign bus.inc       = inc;
  assign bus.dec       = dec;
  assign bus.commit    = commit;
  assign bus.alarm_en  = alarm_en;
  assign bus.sw_run    = sw_run;
  assign bus.sw_clear  = sw_clear;
  assign bus.blink_on  = blink_on;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with a fast timebase (4 clocks per tick).
// Strobes are tallied on the falling edge. Levels are sampled 1 ns after the rising edge.
module tb_clock_mode_controller;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned SET_TIMEOUT  = 8;
  localparam int unsigned BLINK_HALF   = 2;
  localparam int unsigned REPEAT_DELAY = 2;
  localparam int unsigned REPEAT_RATE  = 1;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_INCS = 5;
  localparam bit RPT       = 1'b1;
`else
  localparam int HOLD_INCS = 1;
  localparam bit RPT       = 1'b0;
`endif

  localparam int B_MODE = 0;
  localparam int B_SET  = 1;
  localparam int B_OP1  = 2;
  localparam int B_OP2  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int inc_by_field [4];
  int dec_by_field [4];
  int inc_cnt    = 0;
  int commit_cnt = 0;
  int clear_cnt  = 0;
  int excl_err   = 0;

  clock_mode_if bus();

  clock_mode_controller #(
    .TICK_DIV    (TICK_DIV),
    .SET_TIMEOUT (SET_TIMEOUT),
    .BLINK_HALF  (BLINK_HALF),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle count since reset; its value mod TICK_DIV is the tick phase.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (bus.inc === 1'b1) begin
      inc_by_field[bus.field_sel] <= inc_by_field[bus.field_sel] + 1;
      inc_cnt <= inc_cnt + 1;
    end
    if (bus.dec === 1'b1) dec_by_field[bus.field_sel] <= dec_by_field[bus.field_sel] + 1;
    if (bus.commit === 1'b1) commit_cnt <= commit_cnt + 1;
    if (bus.sw_clear === 1'b1) clear_cnt <= clear_cnt + 1;
    if ((bus.inc === 1'b1 && bus.dec === 1'b1) ||
        (bus.commit === 1'b1 && (bus.inc === 1'b1 || bus.dec === 1'b1)) ||
        bus.mode_sel === 2'd3)
      excl_err <= excl_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      B_MODE:  bus.mode = v;
      B_SET:   bus.set  = v;
      B_OP1:   bus.op1  = v;
      default: bus.op2  = v;
    endcase
  endtask

  task automatic press(input int b);
    drive(b, 1'b1);
    step();
    drive(b, 1'b0);
    step();
  endtask

  // Leaves the bench so that a button driven now is sampled on a tick edge.
  task automatic align();
    for (int i = 0; i < 4 && (cyc % 4) != 3; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, i0, d0, k0;
    bus.mode = 1'b1;
    bus.set  = 1'b0;
    bus.op1  = 1'b0;
    bus.op2  = 1'b0;

    // 1. Reset values, mode held through reset, then three mode presses.
    repeat (3) step();
    check("rst_mode_sel", bus.mode_sel, 0);
    check("rst_field_sel", bus.field_sel, 0);
    check("rst_inc", bus.inc, 0);
    check("rst_dec", bus.dec, 0);
    check("rst_commit", bus.commit, 0);
    check("rst_alarm_en", bus.alarm_en, 0);
    check("rst_sw_run", bus.sw_run, 0);
    check("rst_sw_clear", bus.sw_clear, 0);
    check("rst_blink_on", bus.blink_on, 1);
    reset = 1'b0;
    repeat (3) step();
    check("mode_held_no_edge", bus.mode_sel, 0);
    drive(B_MODE, 1'b0);
    step();
    press(B_MODE);
    check("mode_adv_1", bus.mode_sel, 1);
    press(B_MODE);
    check("mode_adv_2", bus.mode_sel, 2);
    press(B_MODE);
    check("mode_wrap_0", bus.mode_sel, 0);

    // 2. Full set sequence in clock mode.
    c0 = commit_cnt;
    i0 = inc_by_field[1];
    d0 = dec_by_field[2];
    press(B_SET);
    check("set_field_h", bus.field_sel, 1);
    press(B_OP1);
    press(B_OP1);
    press(B_SET);
    check("set_field_m", bus.field_sel, 2);
    press(B_OP2);
    press(B_SET);
    check("set_field_s", bus.field_sel, 3);
    check("set_no_commit_yet", commit_cnt - c0, 0);
    press(B_SET);
    check("set_field_none", bus.field_sel, 0);
    check("set_inc_hour", inc_by_field[1] - i0, 2);
    check("set_dec_min", dec_by_field[2] - d0, 1);
    check("set_commit_once", commit_cnt - c0, 1);
    check("set_mode_frozen", bus.mode_sel, 0);

    // 3. Idle in SET_H: blink every 8 cycles, timeout after 32.
    c0 = commit_cnt;
    align();
    drive(B_SET, 1'b1);
    step();
    check("to_entry_field", bus.field_sel, 1);
    check("to_entry_blink", bus.blink_on, 1);
    drive(B_SET, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      step();
      case (k)
        7:  check("blink_k7", bus.blink_on, 1);
        8:  check("blink_k8", bus.blink_on, 0);
        16: check("blink_k16", bus.blink_on, 1);
        24: check("blink_k24", bus.blink_on, 0);
        31: check("to_k31_field", bus.field_sel, 1);
        32: begin
          check("to_k32_commit", bus.commit, 1);
          check("to_k32_field", bus.field_sel, 0);
          check("to_k32_blink", bus.blink_on, 1);
        end
        33: check("to_k33_commit", bus.commit, 0);
        default: ;
      endcase
    end
    check("to_commit_once", commit_cnt - c0, 1);

    // 4. Stopwatch controls.
    press(B_MODE);
    press(B_MODE);
    check("sw_mode", bus.mode_sel, 2);
    press(B_SET);
    check("sw_set_ignored", bus.field_sel, 0);
    c0 = clear_cnt;
    press(B_OP1);
    check("sw_run_on", bus.sw_run, 1);
    press(B_OP2);
    check("sw_clear_blocked", clear_cnt - c0, 0);
    press(B_OP1);
    check("sw_run_off", bus.sw_run, 0);
    press(B_OP2);
    check("sw_clear_once", clear_cnt - c0, 1);
    press(B_OP1);
    press(B_MODE);
    check("sw_bg_mode", bus.mode_sel, 0);
    check("sw_bg_run", bus.sw_run, 1);

    // 5. Priority in alarm mode, then reset mid-set.
    press(B_MODE);
    check("alarm_mode", bus.mode_sel, 1);
    press(B_OP1);
    check("alarm_armed", bus.alarm_en, 1);
    drive(B_MODE, 1'b1);
    drive(B_OP1, 1'b1);
    step();
    drive(B_MODE, 1'b0);
    drive(B_OP1, 1'b0);
    step();
    check("prio_mode_sel", bus.mode_sel, 2);
    check("prio_alarm_kept", bus.alarm_en, 1);
    press(B_MODE);
    press(B_SET);
    press(B_SET);
    check("mid_set_field", bus.field_sel, 2);
    c0 = commit_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_field", bus.field_sel, 0);
    check("mid_rst_alarm", bus.alarm_en, 0);
    check("mid_rst_sw_run", bus.sw_run, 0);
    step();
    step();
    check("mid_rst_no_commit", commit_cnt - c0, 0);

    // 6. Hold op1 for 24 cycles in SET_H.
    press(B_SET);
    check("hold_field", bus.field_sel, 1);
    i0 = inc_cnt;
    c0 = commit_cnt;
    k0 = 0;
    align();
    drive(B_OP1, 1'b1);
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.inc === 1'b1) k0++;
      case (k)
        0: check("hold_edge_inc", bus.inc, 1);
        7: check("hold_k7_inc", bus.inc, 0);
        8: check("hold_k8_inc", bus.inc, RPT);
        9: check("hold_k9_inc", bus.inc, 0);
        default: ;
      endcase
    end
    drive(B_OP1, 1'b0);
    step();
    step();
    check("hold_inc_total", inc_cnt - i0, HOLD_INCS);
    check("hold_inc_seen", k0, HOLD_INCS);
    check("hold_no_timeout", commit_cnt - c0, 0);
    check("hold_still_set", bus.field_sel, 1);
    press(B_SET);
    press(B_SET);
    press(B_SET);
    check("hold_exit_field", bus.field_sel, 0);
    check("hold_exit_commit", commit_cnt - c0, 1);

    check("strobe_exclusive", excl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
